// File: rtl/ddr_axi_wr_burst.sv
// Drains a first-word-fall-through write-data FIFO into fixed-length AXI4
// INCR write bursts. The burst addresses walk through a wrapping region. A
// new burst starts only after the write response of the previous one.
//
// Handshake rule used on every AXI channel: a transfer happens on a rising
// edge where valid and ready are both 1. Once a valid is raised, it and its
// payload stay unchanged until that edge. AW completes before W starts, and
// all W beats complete before B is accepted.
module ddr_axi_wr_burst #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_WIDTH   = 4,
    parameter int                    BURST_LEN   = 8,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter logic [ADDR_WIDTH-1:0] REGION_SIZE = ADDR_WIDTH'('h1000),
    parameter logic [3:0]            AXI_ID      = 4'h0
) (
    input  logic                    Sys_Clk,
    input  logic                    Sync_Clr,
    input  logic                    I_Enable,
    input  logic [DATA_WIDTH-1:0]   I_Fifo_Data,
    input  logic [NUM_WIDTH-1:0]    I_Fifo_Num,
    input  logic                    I_Fifo_Empty,
    output logic                    O_Fifo_Rd_En,
    output logic [3:0]              O_Awid,
    output logic [ADDR_WIDTH-1:0]   O_Awaddr,
    output logic [7:0]              O_Awlen,
    output logic [2:0]              O_Awsize,
    output logic [1:0]              O_Awburst,
    output logic                    O_Awvalid,
    input  logic                    I_Awready,
    output logic [DATA_WIDTH-1:0]   O_Wdata,
    output logic [DATA_WIDTH/8-1:0] O_Wstrb,
    output logic                    O_Wlast,
    output logic                    O_Wvalid,
    input  logic                    I_Wready,
    input  logic [1:0]              I_Bresp,
    input  logic                    I_Bvalid,
    output logic                    O_Bready,
    output logic                    O_Busy,
    output logic                    O_Resp_Err,
    output logic [15:0]             O_Burst_Cnt,
    output logic [1:0]              dbg_state
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int AW1    = ADDR_WIDTH + 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
    // One extra address bit so the wrap compare cannot overflow at the top of the map
    localparam logic [AW1-1:0]    BURST_BYTES = AW1'(BURST_LEN * STRB_W);
    localparam logic [AW1-1:0]    REGION_END  = {1'b0, BASE_ADDR} + {1'b0, REGION_SIZE};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              state;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [BEAT_W-1:0]   beat_nxt;
    logic [AW1-1:0]      addr_sum;
    logic                w_fire;
    logic                start_ok;

    // Constant AW attributes and the write-data pass-through
    assign O_Awid    = AXI_ID;
    assign O_Awlen   = 8'(BURST_LEN - 1);
    assign O_Awsize  = 3'($clog2(STRB_W));
    assign O_Awburst = 2'b01;
    assign O_Wdata   = I_Fifo_Data;
    assign O_Wstrb   = '1;
    assign dbg_state = state;

    // W is presented straight from the FIFO head, so a pop is a W handshake
    assign O_Wvalid     = (state == S_DATA) & ~I_Fifo_Empty;
    assign w_fire       = O_Wvalid & I_Wready;
    assign O_Fifo_Rd_En = w_fire;

    assign start_ok = I_Enable & (32'(I_Fifo_Num) >= 32'(BURST_LEN));
    assign beat_nxt = beat_cnt + 1'b1;
    assign addr_sum = {1'b0, O_Awaddr} + BURST_BYTES;

    // Burst sequencer: IDLE -> ADDR -> DATA -> RESP, all outputs registered
    always_ff @(posedge Sys_Clk) begin
        if (Sync_Clr) begin
            state       <= S_IDLE;
            O_Awaddr    <= BASE_ADDR;
            O_Awvalid   <= 1'b0;
            O_Wlast     <= 1'b0;
            O_Bready    <= 1'b0;
            O_Busy      <= 1'b0;
            O_Resp_Err  <= 1'b0;
            O_Burst_Cnt <= '0;
            beat_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        state     <= S_ADDR;
                        O_Awvalid <= 1'b1;
                        O_Busy    <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (I_Awready) begin
                        state     <= S_DATA;
                        O_Awvalid <= 1'b0;
                        beat_cnt  <= '0;
                        O_Wlast   <= (BURST_LEN == 1);
                    end
                end
                S_DATA: begin
                    if (w_fire) begin
                        if (O_Wlast) begin
                            state    <= S_RESP;
                            O_Wlast  <= 1'b0;
                            beat_cnt <= '0;
                            O_Bready <= 1'b1;
                        end else begin
                            beat_cnt <= beat_nxt;
                            O_Wlast  <= (beat_nxt == LAST_BEAT);
                        end
                    end
                end
                S_RESP: begin
                    if (I_Bvalid) begin
                        state       <= S_IDLE;
                        O_Bready    <= 1'b0;
                        O_Busy      <= 1'b0;
                        O_Burst_Cnt <= O_Burst_Cnt + 16'd1;
                        if (I_Bresp != 2'b00) begin
                            O_Resp_Err <= 1'b1;
                        end
                        if (addr_sum >= REGION_END) begin
                            O_Awaddr <= BASE_ADDR;
                        end else begin
                            O_Awaddr <= addr_sum[ADDR_WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
